// File: rtl/bsg_wormhole_router_adapter_pkg.sv
// Shared definitions for the wormhole router adapters.
//   - BSG_WORMHOLE_ROUTER_ADAPTER_HEADER_S(x_w, y_w, len_w, payload_w):
//     packed header layout, LSB first: x_cord, y_cord, len, payload.
//   - adapter_state_e: input FSM states (IDLE waits for a header, BODY
//     collects the remaining flits of a packet).
//   - packet_width(): width of an assembled packet word.
`ifndef BSG_WORMHOLE_ROUTER_ADAPTER_PKG_SV
`define BSG_WORMHOLE_ROUTER_ADAPTER_PKG_SV

`define BSG_WORMHOLE_ROUTER_ADAPTER_HEADER_S(x_w, y_w, len_w, payload_w) \
  struct packed {                          \
    logic [(payload_w)-1:0] payload;       \
    logic [(len_w)-1:0]     len;           \
    logic [(y_w)-1:0]       y_cord;        \
    logic [(x_w)-1:0]       x_cord;        \
  }

package bsg_wormhole_router_adapter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } adapter_state_e;

  function automatic int packet_width(input int payload_w, input int len_w,
                                      input int y_w, input int x_w);
    return payload_w + len_w + y_w + x_w;
  endfunction

endpackage

`endif

// File: rtl/bsg_wormhole_router_adapter_out_buf.sv
// One packet buffer of the double-buffered output adapter.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   data_i         : flit to store
//   w_slot_i       : one-hot per-slot write enable
//   set_full_i     : mark the buffer as holding a complete packet
//   clear_i        : consume; zero the data, full flag and written mask
//   data_o         : packet word (unwritten slots read as 0)
//   full_o         : buffer holds a complete packet
module bsg_wormhole_router_adapter_out_buf
  import bsg_wormhole_router_adapter_pkg::*;
#(
  parameter int flit_width_p   = 136,
  parameter int max_num_flit_p = 4,
  parameter int width_p        = 541
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [flit_width_p-1:0]   data_i,
  input  logic [max_num_flit_p-1:0] w_slot_i,
  input  logic                      set_full_i,
  input  logic                      clear_i,
  output logic [width_p-1:0]        data_o,
  output logic                      full_o
);

  logic                      full_r;
  logic [max_num_flit_p-1:0] mask_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      full_r <= 1'b0;
      mask_r <= '0;
    end else if (clear_i) begin
      full_r <= 1'b0;
      mask_r <= '0;
    end else begin
      if (set_full_i) full_r <= 1'b1;
      mask_r <= mask_r | w_slot_i;
    end
  end

  assign full_o = full_r;

  // The last slot is truncated at width_p; slots lying wholly above
  // width_p store nothing but still record their write in the mask.
  for (genvar k = 0; k < max_num_flit_p; k++) begin : g_slot
    localparam int lo_lp = k * flit_width_p;
    if (lo_lp < width_p) begin : g_store
      localparam int w_lp = ((width_p - lo_lp) < flit_width_p) ? (width_p - lo_lp) : flit_width_p;
      logic [w_lp-1:0] slot_r;

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)          slot_r <= '0;
        else if (clear_i)     slot_r <= '0;
        else if (w_slot_i[k]) slot_r <= data_i[w_lp-1:0];
      end

      assign data_o[lo_lp +: w_lp] = mask_r[k] ? slot_r : '0;
    end
  end

endmodule

// File: rtl/bsg_wormhole_router_adapter_out_db.sv
// Double-buffered wormhole output adapter: deserialises header-first
// wormhole flits into one wide packet word per packet. While one buffer
// waits on the consumer the other fills, so a flit can be taken every
// cycle.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   data_i, v_i    : incoming flit and its valid
//   ready_o        : a flit can be accepted this cycle
//   data_o, v_o    : assembled packet and its valid
//   ready_i        : consumer takes the packet
//   len_err_o      : one-cycle pulse after a header with len >= max_num_flit_p
module bsg_wormhole_router_adapter_out_db
  import bsg_wormhole_router_adapter_pkg::*;
#(
  parameter int flit_width_p        = 136,
  parameter int max_num_flit_p      = 4,
  parameter int x_cord_width_p      = 1,
  parameter int y_cord_width_p      = 1,
  parameter int max_payload_width_p = 537,
  localparam int len_width_lp       = $clog2(max_num_flit_p),
  localparam int packet_width_lp    = packet_width(max_payload_width_p, len_width_lp,
                                                   y_cord_width_p, x_cord_width_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [flit_width_p-1:0]    data_i,
  input  logic                       v_i,
  output logic                       ready_o,
  output logic [packet_width_lp-1:0] data_o,
  output logic                       v_o,
  input  logic                       ready_i,
  output logic                       len_err_o
);

  typedef `BSG_WORMHOLE_ROUTER_ADAPTER_HEADER_S(x_cord_width_p, y_cord_width_p, len_width_lp,
    flit_width_p - len_width_lp - y_cord_width_p - x_cord_width_p) header_s;
  typedef logic [len_width_lp:0] count_t;

  localparam count_t max_len_lp = count_t'(max_num_flit_p - 1);

  adapter_state_e            state_r;
  count_t                    count_r;
  logic [len_width_lp-1:0]   len_r;
  logic                      wr_ptr_r;
  logic                      rd_ptr_r;
  logic                      len_err_r;

  header_s                   hdr;
  logic [flit_width_p-1:0]   flit;
  logic                      hdr_sat;
  logic [len_width_lp-1:0]   hdr_len;
  logic                      accept;
  logic                      consume;
  logic                      last;
  count_t                    slot_sel;
  logic [max_num_flit_p-1:0] slot_oh;
  logic [1:0]                full;
  logic [packet_width_lp-1:0] buf_data [2];

  assign hdr  = data_i;
  assign flit = hdr;

  // len is only meaningful on the header flit; oversize values clamp to
  // the last slot so the packet still terminates.
  assign hdr_sat = count_t'(hdr.len) > max_len_lp;
  assign hdr_len = hdr_sat ? max_len_lp[len_width_lp-1:0] : hdr.len;

  assign ready_o = ~full[wr_ptr_r] & ~reset_i;
  assign accept  = v_i & ready_o;
  assign v_o     = full[rd_ptr_r];
  assign data_o  = buf_data[rd_ptr_r];
  assign consume = v_o & ready_i;

  assign slot_sel = (state_r == IDLE) ? '0 : count_r;
  assign slot_oh  = {{(max_num_flit_p-1){1'b0}}, 1'b1} << slot_sel;
  assign last     = (state_r == IDLE) ? (hdr_len == '0) : (count_r == count_t'(len_r));

  for (genvar b = 0; b < 2; b++) begin : g_buf
    bsg_wormhole_router_adapter_out_buf #(
      .flit_width_p  (flit_width_p),
      .max_num_flit_p(max_num_flit_p),
      .width_p       (packet_width_lp)
    ) u_buf (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .data_i    (flit),
      .w_slot_i  ((accept && (wr_ptr_r == 1'(b))) ? slot_oh : '0),
      .set_full_i(accept & last & (wr_ptr_r == 1'(b))),
      .clear_i   (consume & (rd_ptr_r == 1'(b))),
      .data_o    (buf_data[b]),
      .full_o    (full[b])
    );
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r   <= IDLE;
      count_r   <= '0;
      len_r     <= '0;
      wr_ptr_r  <= 1'b0;
      rd_ptr_r  <= 1'b0;
      len_err_r <= 1'b0;
    end else begin
      len_err_r <= accept & (state_r == IDLE) & hdr_sat;
      if (consume) rd_ptr_r <= ~rd_ptr_r;
      if (accept) begin
        if (last) wr_ptr_r <= ~wr_ptr_r;
        case (state_r)
          IDLE: begin
            len_r   <= hdr_len;
            count_r <= count_t'(1);
            state_r <= last ? IDLE : BODY;
          end
          BODY: begin
            count_r <= count_r + 1'b1;
            if (last) state_r <= IDLE;
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  assign len_err_o = len_err_r;

endmodule

// File: tb/tb_bsg_wormhole_router_adapter_out_db.sv
module tb_bsg_wormhole_router_adapter_out_db;

  logic         clk;
  logic         rst;
  logic [135:0] data_i;
  logic         v_i;
  logic         ready_o;
  logic [540:0] data_o;
  logic         v_o;
  logic         ready_i;
  logic         len_err;

  logic [135:0] data_b;
  logic         v_b;
  logic         ready_o_b;
  logic [403:0] data_o_b;
  logic         v_o_b;
  logic         ready_i_b;
  logic         len_err_b;

  int checks   = 0;
  int passes   = 0;
  int consumed = 0;
  logic [540:0] exp_q [$];

  bsg_wormhole_router_adapter_out_db dut (
    .clk_i(clk), .reset_i(rst), .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
    .data_o(data_o), .v_o(v_o), .ready_i(ready_i), .len_err_o(len_err)
  );

  bsg_wormhole_router_adapter_out_db #(
    .flit_width_p(136), .max_num_flit_p(3), .x_cord_width_p(1),
    .y_cord_width_p(1), .max_payload_width_p(400)
  ) dut_sat (
    .clk_i(clk), .reset_i(rst), .data_i(data_b), .v_i(v_b), .ready_o(ready_o_b),
    .data_o(data_o_b), .v_o(v_o_b), .ready_i(ready_i_b), .len_err_o(len_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkw(input string tag, input logic [543:0] obs, input logic [543:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  function automatic logic [135:0] rnd_body();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[135:0];
  endfunction

  function automatic logic [135:0] rnd_flit(input logic [1:0] len);
    logic [135:0] f;
    f = rnd_body();
    f[3:2] = len;
    return f;
  endfunction

  function automatic logic [540:0] pack(input logic [135:0] f0, input logic [135:0] f1,
                                        input logic [135:0] f2, input logic [135:0] f3,
                                        input int n);
    logic [543:0] p;
    p = '0;
    p[135:0] = f0;
    if (n > 1) p[271:136] = f1;
    if (n > 2) p[407:272] = f2;
    if (n > 3) p[543:408] = f3;
    return p[540:0];
  endfunction

  // Scoreboard: a packet handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && v_o && ready_i) begin
      checkw("sb_depth", 544'(exp_q.size() > 0), 544'(1));
      if (exp_q.size() > 0) checkw("sb_pkt", 544'(data_o), 544'(exp_q.pop_front()));
      consumed++;
    end
  end

  task automatic send(input logic [135:0] f, output int waits);
    data_i = f;
    v_i    = 1'b1;
    waits  = 0;
    forever begin
      @(negedge clk);
      if (ready_o || waits > 50) break;
      waits++;
    end
    if (waits > 50) check1("send_timeout", ready_o, 1'b1);
    @(posedge clk);
    #1;
    v_i = 1'b0;
  endtask

  task automatic wait_consumed(input string tag, input int target);
    int n;
    n = 0;
    while (consumed < target && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checkw(tag, 544'(consumed), 544'(target));
  endtask

  initial begin
    logic [135:0] f0, f1, f2, f3, h;
    logic [540:0] exp1;
    logic [543:0] pb;
    int w;

    rst = 1'b1; v_i = 1'b0; data_i = '0; ready_i = 1'b0;
    v_b = 1'b0; data_b = '0; ready_i_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_v_o", v_o, 1'b0);
    checkw("rst_data_o", 544'(data_o), 544'(0));
    check1("rst_ready_o", ready_o, 1'b0);
    check1("rst_len_err", len_err, 1'b0);
    rst = 1'b0;
    #1;
    check1("ready_after_rst", ready_o, 1'b1);

    // Held packet plus a partial one, then asynchronous reset mid-cycle.
    f0 = rnd_flit(2'd0);
    exp_q.push_back(pack(f0, '0, '0, '0, 1));
    send(f0, w);
    h = rnd_flit(2'd2);
    send(h, w);
    send(rnd_body(), w);
    check1("pre_rst_v_o", v_o, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check1("midrst_v_o", v_o, 1'b0);
    checkw("midrst_data_o", 544'(data_o), 544'(0));
    check1("midrst_ready_o", ready_o, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check1("postrst_ready_o", ready_o, 1'b1);
    check1("postrst_v_o", v_o, 1'b0);
    f0 = rnd_flit(2'd0);
    exp_q.push_back(pack(f0, '0, '0, '0, 1));
    send(f0, w);
    check1("fresh_v_o", v_o, 1'b1);
    ready_i = 1'b1;
    wait_consumed("fresh_drain", 1);

    // Single-flit packet.
    ready_i = 1'b0;
    f0 = rnd_body();
    f0[7:0] = 8'hA1;
    exp_q.push_back(pack(f0, '0, '0, '0, 1));
    send(f0, w);
    check1("single_v_o", v_o, 1'b1);
    checkw("single_low", 544'(data_o[135:0]), 544'(f0));
    checkw("single_high_zero", 544'(data_o[540:136]), 544'(0));
    ready_i = 1'b1;
    wait_consumed("single_drain", 2);

    // Full-length packet streamed with the consumer ready.
    f0 = rnd_flit(2'd3); f1 = rnd_body(); f2 = rnd_body(); f3 = rnd_body();
    exp_q.push_back(pack(f0, f1, f2, f3, 4));
    send(f0, w);
    checkw("full_stall0", 544'(w), 544'(0));
    check1("full_no_len_err", len_err, 1'b0);
    send(f1, w);
    checkw("full_stall1", 544'(w), 544'(0));
    send(f2, w);
    checkw("full_stall2", 544'(w), 544'(0));
    check1("full_not_early", v_o, 1'b0);
    send(f3, w);
    checkw("full_stall3", 544'(w), 544'(0));
    check1("full_v_o", v_o, 1'b1);
    wait_consumed("full_drain", 3);

    // Back-pressure: two len=1 packets fill both buffers.
    ready_i = 1'b0;
    f0 = rnd_flit(2'd1); f1 = rnd_body(); f2 = rnd_flit(2'd1); f3 = rnd_body();
    exp1 = pack(f0, f1, '0, '0, 2);
    exp_q.push_back(exp1);
    exp_q.push_back(pack(f2, f3, '0, '0, 2));
    send(f0, w);
    send(f1, w);
    send(f2, w);
    send(f3, w);
    checkw("bp_no_stall", 544'(w), 544'(0));
    check1("bp_ready_low", ready_o, 1'b0);
    check1("bp_v_o", v_o, 1'b1);
    checkw("bp_hold_data", 544'(data_o), 544'(exp1));
    ready_i = 1'b1;
    wait_consumed("bp_drain", 5);
    check1("bp_ready_back", ready_o, 1'b1);
    check1("bp_v_o_low", v_o, 1'b0);

    // Consume A on the same edge as B's last flit.
    ready_i = 1'b0;
    f0 = rnd_flit(2'd0); f1 = rnd_flit(2'd1); f2 = rnd_body();
    exp_q.push_back(pack(f0, '0, '0, '0, 1));
    exp_q.push_back(pack(f1, f2, '0, '0, 2));
    send(f0, w);
    send(f1, w);
    ready_i = 1'b1;
    send(f2, w);
    checkw("ovl_stall", 544'(w), 544'(0));
    check1("ovl_v_o_b", v_o, 1'b1);
    checkw("ovl_a_out", 544'(consumed), 544'(6));
    wait_consumed("ovl_drain", 7);

    // len saturation on the 3-flit instance.
    f0 = rnd_flit(2'd3); f1 = rnd_body(); f2 = rnd_body();
    pb = '0;
    pb[135:0] = f0; pb[271:136] = f1; pb[407:272] = f2;
    data_b = f0;
    v_b = 1'b1;
    @(negedge clk);
    check1("sat_ready", ready_o_b, 1'b1);
    @(posedge clk);
    #1;
    check1("sat_err_pulse", len_err_b, 1'b1);
    data_b = f1;
    @(posedge clk);
    #1;
    check1("sat_err_once", len_err_b, 1'b0);
    check1("sat_not_early", v_o_b, 1'b0);
    data_b = f2;
    @(posedge clk);
    #1;
    v_b = 1'b0;
    check1("sat_v_o", v_o_b, 1'b1);
    checkw("sat_data", 544'(data_o_b), 544'(pb[403:0]));
    ready_i_b = 1'b1;
    @(posedge clk);
    #1;
    check1("sat_consumed", v_o_b, 1'b0);
    check1("sat_err_quiet", len_err_b, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
